imem_loader: RTL and testbench

Boot-time program loader: accepts a byte stream over a valid/ready handshake and writes 16-bit little-endian words sequentially into the instruction `block_ram` through its write port. It drives the instruction memory's write side, which the processor never uses. It holds `top_processor` in reset until the image is fully written, then releases it.

---
 rtl/imem_loader_pkg.sv | 10 +
 rtl/imem_loader_le_word_assembler.sv | 30 +++
 rtl/imem_loader.sv | 93 +++++++++
 tb/tb_imem_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader states, stream framing constants and address width
package imem_loader_pkg;
   localparam int LOADER_ADDR_W  = 16;
   localparam int LEN_BYTES      = 2;
   localparam int BYTES_PER_WORD = 2;
   typedef enum logic [3:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI,
      S_WRITE, S_CSUM_LO, S_CSUM_HI, S_DONE, S_ERROR
   } state_t;
endpackage

// File: rtl/imem_loader_le_word_assembler.sv
// le_word_assembler: joins a low byte and a later high byte into a little-endian word
module le_word_assembler import imem_loader_pkg::*; (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_lo_en,
   input  logic                          i_hi_en,
   input  logic [7:0]                    i_byte,
   output logic [8*BYTES_PER_WORD-1:0]   o_peek,
   output logic [8*BYTES_PER_WORD-1:0]   o_word,
   output logic                          o_valid
);
   logic [7:0]                  r_lo;
   logic [8*BYTES_PER_WORD-1:0] r_word;
   logic                        r_valid;
   assign o_peek  = {i_byte, r_lo};
   assign o_word  = r_word;
   assign o_valid = r_valid;
   // latch the low byte, then register the full word with a one-cycle valid
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_lo    <= '0;
         r_word  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (i_lo_en) r_lo <= i_byte;
         if (i_hi_en) r_word <= o_peek;
         r_valid <= i_hi_en;
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader writing a LE word stream into instruction RAM; IMEM_LOADER_CHECKSUM_EN adds a trailing checksum
module imem_loader import imem_loader_pkg::*; #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_valid,
   output logic        o_rx_ready,
   output logic [15:0] o_mem_address,
   output logic [15:0] o_mem_data_write,
   output logic        o_mem_write_enable,
   output logic        o_cpu_reset,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error
);
   localparam int HDR_W = 8*LEN_BYTES;
   localparam logic [HDR_W-1:0] MAXW = HDR_W'(MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t TAIL = S_CSUM_LO;
`else
   localparam state_t TAIL = S_DONE;
`endif
   state_t                   r_state, w_next;
   logic [HDR_W-1:0]         r_len;
   logic [LOADER_ADDR_W-1:0] r_index;
   logic [15:0]              w_peek, w_word;
   logic                     w_word_valid, w_xfer, w_go, w_we, w_lo_en, w_hi_en;
   assign w_xfer     = i_rx_valid & o_rx_ready;
   assign w_go       = i_start & (r_state inside {S_IDLE, S_DONE, S_ERROR});
   assign w_lo_en    = w_xfer & (r_state inside {S_LEN_LO, S_DAT_LO, S_CSUM_LO});
   assign w_hi_en    = w_xfer & (r_state inside {S_LEN_HI, S_DAT_HI, S_CSUM_HI});
   assign w_we       = (r_state == S_WRITE) & w_word_valid;
   assign o_rx_ready = r_state inside {S_LEN_LO, S_LEN_HI, S_DAT_LO, S_DAT_HI, S_CSUM_LO, S_CSUM_HI};
   assign o_busy     = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
   assign o_done     = r_state == S_DONE;
   assign o_error    = r_state == S_ERROR;
   assign o_cpu_reset        = r_state != S_DONE;
   assign o_mem_write_enable = w_we;
   assign o_mem_address      = w_we ? BASE_ADDR + r_index : '0;
   assign o_mem_data_write   = w_we ? w_word : '0;
   le_word_assembler u_asm (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_lo_en (w_lo_en),
      .i_hi_en (w_hi_en),
      .i_byte  (i_rx_data),
      .o_peek  (w_peek),
      .o_word  (w_word),
      .o_valid (w_word_valid)
   );
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [15:0] r_sum;
   // running modulo-2^16 sum of the data words actually written
   always_ff @(posedge i_clk) begin
      if (i_reset || w_go) r_sum <= '0;
      else if (w_we) r_sum <= r_sum + w_word;
   end
`endif
   // next-state decode; the header length is checked as its high byte arrives
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: w_next = i_start ? S_LEN_LO : r_state;
         S_LEN_LO: w_next = w_xfer ? S_LEN_HI : r_state;
         S_LEN_HI: w_next = !w_xfer ? r_state : (w_peek > MAXW) ? S_ERROR : (w_peek == '0) ? TAIL : S_DAT_LO;
         S_DAT_LO: w_next = w_xfer ? S_DAT_HI : r_state;
         S_DAT_HI: w_next = w_xfer ? S_WRITE : r_state;
         S_WRITE:  w_next = (r_index + 1'b1 < r_len) ? S_DAT_LO : TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM_LO: w_next = w_xfer ? S_CSUM_HI : r_state;
         S_CSUM_HI: w_next = !w_xfer ? r_state : (w_peek == r_sum) ? S_DONE : S_ERROR;
`endif
         default:  w_next = S_IDLE;
      endcase
   end
   // state, word index and latched image length
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_index <= '0;
         r_len   <= '0;
      end else begin
         r_state <= w_next;
         if (w_go) r_index <= '0;
         else if (w_we) r_index <= r_index + 1'b1;
         if (r_state == S_LEN_HI && w_xfer) r_len <= w_peek;
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads with a write scoreboard and a RAM model for read-back
module tb_imem_loader;
   localparam logic [15:0] BASE = 16'h0010;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif
   typedef struct {
      int              n;
      logic [3:0][15:0] w;
      logic [15:0]     cs;
      bit              gap;
      bit              mid_start;
   } vec_t;
   logic        clk = 0, reset = 1, start = 0, rx_valid = 0;
   logic [7:0]  rx_data = 0;
   logic        rx_ready, mem_we, cpu_reset, busy, done, error;
   logic [15:0] addr, data;
   int          cyc = 0, last_we = 0, wr_count = 0, n_cmp = 0, n_bad = 0;
   logic [31:0] exp_q [$];
   logic [15:0] mem [logic [15:0]];
   vec_t        tbl [7];
   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024)) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
      .o_rx_ready(rx_ready), .o_mem_address(addr), .o_mem_data_write(data),
      .o_mem_write_enable(mem_we), .o_cpu_reset(cpu_reset), .o_busy(busy),
      .o_done(done), .o_error(error)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask
   // write monitor: pops the scoreboard and updates the RAM model
   always @(negedge clk) begin
      if (mem_we) begin
         last_we = cyc;
         wr_count++;
         chk("ready_during_write", rx_ready, 0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %h data %h want none", addr, data);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", addr, e[31:16]);
            chk("wr_data", data, e[15:0]);
         end
         mem[addr] = data;
      end
   end
   function automatic vec_t mk(int n, logic [15:0] w0, logic [15:0] w1, logic [15:0] w2,
                               logic [15:0] cs, bit gap, bit ms);
      vec_t v;
      v.n = n; v.w = {16'h0, w2, w1, w0}; v.cs = cs; v.gap = gap; v.mid_start = ms;
      return v;
   endfunction
   task automatic pulse_start();
      start = 1;
      @(negedge clk);
      start = 0;
   endtask
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int t = 0;
      if (gap) begin
         rx_valid = 0;
         @(negedge clk);
      end
      rx_valid = 1;
      rx_data  = b;
      while (!rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!rx_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rx_ready_timeout: got 0 want 1");
      end
      @(negedge clk);
   endtask
   task automatic check_reset_vals(input string tag);
      chk({tag, "_rx_ready"}, rx_ready, 0);
      chk({tag, "_we"}, mem_we, 0);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_data"}, data, 0);
      chk({tag, "_cpu_reset"}, cpu_reset, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_error"}, error, 0);
   endtask
   task automatic do_reset();
      rx_valid = 0;
      reset = 1;
      @(negedge clk);
      reset = 0;
   endtask
   task automatic run_vec(input vec_t v);
      logic [15:0] sum = 0;
      logic [15:0] n16;
      bit ok;
      int sc, dc, t = 0;
      n16 = 16'(v.n);
      for (int i = 0; i < v.n; i++) sum += v.w[i];
      ok = CS ? (sum == v.cs) : 1'b1;
      pulse_start();
      sc = cyc;
      send_byte(n16[7:0], v.gap);
      send_byte(n16[15:8], v.gap);
      for (int i = 0; i < v.n; i++) begin
         exp_q.push_back({BASE + 16'(i), v.w[i]});
         if (v.mid_start && i == 1) start = 1;
         send_byte(v.w[i][7:0], v.gap);
         send_byte(v.w[i][15:8], v.gap);
         start = 0;
      end
      if (CS) begin
         send_byte(v.cs[7:0], v.gap);
         send_byte(v.cs[15:8], v.gap);
      end
      rx_valid = 0;
      while (!(done || error) && t < 40) begin
         @(negedge clk);
         t++;
      end
      dc = cyc;
      chk("done", done, ok);
      chk("error", error, !ok);
      chk("cpu_reset", cpu_reset, !ok);
      chk("busy_end", busy, 0);
      chk("pending_writes", exp_q.size(), 0);
      if (!v.gap) begin
         chk("latency_from_start", dc - sc, 2 + 3 * v.n + 2 * CS);
         if (v.n > 0) chk("latency_after_write", dc - last_we, CS ? 3 : 1);
      end
      for (int i = 0; i < v.n; i++) chk("readback", mem[BASE + 16'(i)], v.w[i]);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int wc;
      tbl[0] = mk(3, 16'h1234, 16'hABCD, 16'h0001, 16'hBE02, 0, 0);
      tbl[1] = mk(3, 16'h1234, 16'hABCD, 16'h0001, 16'hBE02, 1, 0);
      tbl[2] = mk(1, 16'hBEEF, 16'h0, 16'h0, 16'hBEEF, 0, 0);
      tbl[3] = mk(0, 16'h0, 16'h0, 16'h0, 16'h0000, 0, 0);
      tbl[4] = mk(2, 16'hFFFF, 16'h0002, 16'h0, 16'h0001, 0, 0);
      tbl[5] = mk(2, 16'hFFFF, 16'h0002, 16'h0, 16'h0002, 0, 0);
      tbl[6] = mk(2, 16'h1111, 16'h2222, 16'h0, 16'h3333, 0, 1);
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      reset = 0;
      @(negedge clk);
      for (int i = 0; i < 4; i++) run_vec(tbl[i]);
      wc = wr_count;
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      rx_valid = 0;
      chk("ovf_error", error, 1);
      chk("ovf_done", done, 0);
      chk("ovf_cpu_reset", cpu_reset, 1);
      chk("ovf_rx_ready", rx_ready, 0);
      chk("ovf_busy", busy, 0);
      chk("ovf_writes", wr_count - wc, 0);
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      rx_valid = 0;
      chk("max_error", error, 0);
      chk("max_rx_ready", rx_ready, 1);
      chk("max_busy", busy, 1);
      do_reset();
      check_reset_vals("max_rst");
      for (int i = 4; i < 6; i++) run_vec(tbl[i]);
      run_vec(tbl[4]);
      pulse_start();
      chk("restart_cpu_reset", cpu_reset, 1);
      chk("restart_done", done, 0);
      chk("restart_busy", busy, 1);
      chk("restart_rx_ready", rx_ready, 1);
      do_reset();
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      exp_q.push_back({BASE, 16'h5A5A});
      send_byte(8'h5A, 0);
      send_byte(8'h5A, 0);
      rx_valid = 0;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      check_reset_vals("mid_rst");
      reset = 0;
      chk("mid_rst_word0", mem[BASE], 16'h5A5A);
      chk("mid_rst_pending", exp_q.size(), 0);
      @(negedge clk);
      run_vec(tbl[6]);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
